// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared defines for the bus arbiter slice
package bus_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_HOLD_DEF = 15;
  localparam int HOLD_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;
endpackage

// File: rtl/bus_arbiter_decoder.sv
// bus_arbiter_decoder: enabled binary-to-one-hot decoder
module bus_arbiter_decoder
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]      S,
  input  logic                  EN,
  output logic [2**WIDTH-1:0]   Y
);
  // one-hot of S, all-zero while disabled
  always_comb begin
    Y = '0;
    Y[S] = EN;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with hold limit and one-cycle turnaround
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2**WIDTH-1:0] req,
  output logic [2**WIDTH-1:0] gnt,
  output logic [WIDTH-1:0]    select,
  output logic                EN,
  output logic                busy
);
  localparam int N = 2**WIDTH;
  arb_state_e        state_q;
  logic [WIDTH-1:0]  select_q;
  logic [WIDTH-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic              en_q;
  logic              busy_q;
  logic [WIDTH-1:0]  winner_d;
  logic              release_d;

  function automatic logic [WIDTH-1:0] rr_pick(input logic [N-1:0] r, input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] idx;
    logic             found;
    rr_pick = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = p + WIDTH'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found = 1'b1;
      end
    end
  endfunction

  // winner search from ptr and release condition for the current owner
  always_comb begin
    winner_d = rr_pick(req, ptr_q);
    release_d = !req[select_q] || hold_q == HOLD_W'(MAX_HOLD);
  end

  // arbitration FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      select_q <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (|req) begin
          state_q  <= ST_OWN;
          select_q <= winner_d;
          en_q     <= 1'b1;
          busy_q   <= 1'b1;
          hold_q   <= 8'd1;
        end
        ST_OWN: if (release_d) begin
          state_q <= ST_TURN;
          en_q    <= 1'b0;
          ptr_q   <= select_q + 1'b1;
          hold_q  <= '0;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
        ST_TURN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  bus_arbiter_decoder #(.WIDTH(WIDTH)) u_dec (
    .S  (select_q),
    .EN (en_q),
    .Y  (gnt)
  );

  assign select = select_q;
  assign EN     = en_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, corner sequences and random run against a reference model
module tb_bus_arbiter;
  localparam int WIDTH = 3;
  localparam int MAX_HOLD = 4;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [2:0]   select;
  logic         EN;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_owner = -1;
  int m_last = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_turn = 0;
  bit prev_en = 0;
  logic [2:0] prev_sel = '0;

  typedef struct packed {
    logic         rn;
    logic [N-1:0] r;
    logic         en;
    logic [N-1:0] g;
    logic [2:0]   sel;
    logic         bsy;
  } vec_t;
  vec_t tbl[$];

  int seq_en[13]  = '{1,1,1,1,0,0,1,1,1,1,0,0,1};
  int seq_sel[13] = '{0,0,0,0,0,0,7,7,7,7,7,7,0};

  bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .select (select),
    .EN     (EN),
    .busy   (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: one owner at a time, fixed hold limit, a turnaround cycle, then a scan from ptr
  task automatic model(input bit rn, input logic [N-1:0] r);
    bit found;
    if (!rn) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_cnt = 0; m_turn = 0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner] || m_cnt == MAX_HOLD) begin
        m_turn = 1; m_last = m_owner; m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else m_cnt++;
    end else if (m_turn) begin
      m_turn = 0;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++)
        if (!found && r[(m_ptr + k) % N]) begin
          found = 1; m_owner = (m_ptr + k) % N; m_last = m_owner; m_cnt = 1;
        end
    end
  endtask

  task automatic step();
    logic [N-1:0] eg;
    @(posedge clk);
    model(rst_n, req);
    #1;
    cyc++;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("model", {busy, EN, select, gnt},
        {(m_owner >= 0 || m_turn), (m_owner >= 0), 3'(m_last), eg});
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (EN) chk("decode", gnt, N'(1) << select);
    else chk("gnt_zero_when_off", gnt, 0);
    if (EN && prev_en) chk("no_gapless_handover", select, prev_sel);
    prev_en = EN;
    prev_sel = select;
  endtask

  task automatic add(input int n, input bit rn, input logic [N-1:0] r, input bit en,
                     input logic [N-1:0] g, input logic [2:0] sel, input bit bsy);
    for (int i = 0; i < n; i++) tbl.push_back('{rn, r, en, g, sel, bsy});
  endtask

  initial begin
    rst_n = 0;
    req = '0;
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(5, 1, 8'h00, 0, 8'h00, 0, 0);
    add(3, 1, 8'h01, 1, 8'h01, 0, 1);
    add(1, 1, 8'h00, 0, 8'h00, 0, 1);
    add(1, 1, 8'h00, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(4, 1, 8'h24, 1, 8'h04, 2, 1);
    add(1, 1, 8'h24, 0, 8'h00, 2, 1);
    add(1, 1, 8'h24, 0, 8'h00, 2, 0);
    add(4, 1, 8'h24, 1, 8'h20, 5, 1);
    add(1, 1, 8'h24, 0, 8'h00, 5, 1);
    add(1, 1, 8'h24, 0, 8'h00, 5, 0);
    add(1, 1, 8'h24, 1, 8'h04, 2, 1);
    foreach (tbl[i]) begin
      rst_n = tbl[i].rn;
      req = tbl[i].r;
      step();
      chk($sformatf("vec%0d", i), {busy, EN, select, gnt},
          {tbl[i].bsy, tbl[i].en, tbl[i].sel, tbl[i].g});
    end

    rst_n = 0; req = '0; step();
    rst_n = 1; req = 8'h81;
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("wrap%0d", i), {EN, select}, {1'(seq_en[i]), 3'(seq_sel[i])});
    end

    rst_n = 0; req = '0; step();
    rst_n = 1; req = 8'h08; step(); step();
    chk("own3_before_reset", {EN, gnt}, {1'b1, 8'h08});
    rst_n = 0; req = 8'h28; step();
    chk("reset_mid_own", {busy, EN, select, gnt}, 13'h0);
    rst_n = 1; step();
    chk("first_after_reset", {EN, select, gnt}, {1'b1, 3'd3, 8'h08});

    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
